// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl
// Stage-1 operand fetch sequencer. Takes one request at a time and
// resolves it into a 32-bit operand for stage 2. The operand comes from
// a RAM read, an input-device read (with timeout), a zero-extended
// constant, or an error result for the illegal select.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_mblock[1:0], req_source[7:0]  source select and source field
//   ram_rd_en, ram_address, ram_rd_ack, ram_value    RAM read handshake
//   io_rd_en, io_device_id, io_rd_ack, io_value      device read handshake
//   out_valid/out_ready, vr_value, out_error         result to stage 2
//   err_count                       saturating count of error results
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no request in flight, ready for a new one
// RAM_WAIT | ram_rd_en held high, waiting for ram_rd_ack
// IO_WAIT  | io_rd_en held high, waiting for io_rd_ack or timeout
// HOLD     | result presented to stage 2 until consumed

module operand_fetch_ctrl #(
  parameter int IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_mblock,
  input  logic [7:0]  req_source,
  output logic        ram_rd_en,
  output logic [15:0] ram_address,
  input  logic        ram_rd_ack,
  input  logic [31:0] ram_value,
  output logic        io_rd_en,
  output logic [7:0]  io_device_id,
  input  logic        io_rd_ack,
  input  logic [31:0] io_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] vr_value,
  output logic        out_error,
  output logic [15:0] err_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RAM_WAIT = 2'd1;
  localparam logic [1:0] IO_WAIT  = 2'd2;
  localparam logic [1:0] HOLD     = 2'd3;

  localparam logic [1:0] SEL_RAM   = 2'd0;
  localparam logic [1:0] SEL_ILLEG = 2'd1;
  localparam logic [1:0] SEL_IO    = 2'd2;
  localparam logic [1:0] SEL_CONST = 2'd3;

  localparam logic [7:0] IO_LAST = 8'(IO_TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] src_q;
  logic [7:0] io_cnt;
  logic       accept;

  // A result in HOLD can be replaced in the same cycle it is consumed.
  assign req_ready    = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept       = req_valid && req_ready;
  assign ram_address  = {8'h00, src_q};
  assign io_device_id = src_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      src_q     <= 8'h00;
      io_cnt    <= 8'h00;
      ram_rd_en <= 1'b0;
      io_rd_en  <= 1'b0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
      vr_value  <= 32'h0;
      err_count <= 16'h0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          // Acceptance overrides the plain drain above.
          if (accept) begin
            src_q <= req_source;
            case (req_mblock)
              SEL_RAM: begin
                state     <= RAM_WAIT;
                ram_rd_en <= 1'b1;
                out_valid <= 1'b0;
              end
              SEL_IO: begin
                state     <= IO_WAIT;
                io_rd_en  <= 1'b1;
                io_cnt    <= 8'h00;
                out_valid <= 1'b0;
              end
              SEL_CONST: begin
                state     <= HOLD;
                vr_value  <= {24'h0, req_source};
                out_error <= 1'b0;
                out_valid <= 1'b1;
              end
              SEL_ILLEG: begin
                state     <= HOLD;
                vr_value  <= 32'h0;
                out_error <= 1'b1;
                out_valid <= 1'b1;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'h1;
              end
              default: ;
            endcase
          end
        end
        RAM_WAIT: begin
          if (ram_rd_ack) begin
            vr_value  <= ram_value;
            out_error <= 1'b0;
            ram_rd_en <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        IO_WAIT: begin
          // Ack is checked first so an ack on the last cycle is not a timeout.
          if (io_rd_ack) begin
            vr_value  <= io_value;
            out_error <= 1'b0;
            io_rd_en  <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (io_cnt == IO_LAST) begin
            vr_value  <= 32'h0;
            out_error <= 1'b1;
            io_rd_en  <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'h1;
          end else begin
            io_cnt <= io_cnt + 8'h1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
module tb_operand_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mblock;
  logic [7:0]  req_source;
  logic        ram_rd_en;
  logic [15:0] ram_address;
  logic        ram_rd_ack;
  logic [31:0] ram_value;
  logic        io_rd_en;
  logic [7:0]  io_device_id;
  logic        io_rd_ack;
  logic [31:0] io_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] vr_value;
  logic        out_error;
  logic [15:0] err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_fetch_ctrl #(.IO_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mblock(req_mblock), .req_source(req_source),
    .ram_rd_en(ram_rd_en), .ram_address(ram_address),
    .ram_rd_ack(ram_rd_ack), .ram_value(ram_value),
    .io_rd_en(io_rd_en), .io_device_id(io_device_id),
    .io_rd_ack(io_rd_ack), .io_value(io_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .vr_value(vr_value), .out_error(out_error),
    .err_count(err_count)
  );

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_mblock = 2'd0; req_source = 8'h00;
    ram_rd_ack = 1'b0; ram_value = 32'h0; io_rd_ack = 1'b0; io_value = 32'h0;
    out_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    #1;
    checks++; if (ram_rd_en !== 1'b0) begin failures++; $display("FAIL reset_ram_rd_en got=%b exp=0", ram_rd_en); end
    checks++; if (io_rd_en !== 1'b0) begin failures++; $display("FAIL reset_io_rd_en got=%b exp=0", io_rd_en); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_error !== 1'b0) begin failures++; $display("FAIL reset_out_error got=%b exp=0", out_error); end
    checks++; if (vr_value !== 32'h0) begin failures++; $display("FAIL reset_vr_value got=%h exp=0", vr_value); end
    checks++; if (ram_address !== 16'h0) begin failures++; $display("FAIL reset_ram_address got=%h exp=0", ram_address); end
    checks++; if (io_device_id !== 8'h0) begin failures++; $display("FAIL reset_io_device_id got=%h exp=0", io_device_id); end
    checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_const();
    req_valid = 1'b1; req_mblock = 2'd3; req_source = 8'hA5;
    tick();
    req_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL const_out_valid got=%b exp=1", out_valid); end
    checks++; if (vr_value !== 32'h000000A5) begin failures++; $display("FAIL const_vr_value got=%h exp=000000a5", vr_value); end
    checks++; if (out_error !== 1'b0) begin failures++; $display("FAIL const_out_error got=%b exp=0", out_error); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL const_req_ready_hold got=%b exp=0", req_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || vr_value !== 32'h000000A5) begin
        failures++; $display("FAIL const_hold%0d valid=%b value=%h exp valid=1 value=000000a5", i, out_valid, vr_value);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL const_req_ready_drain got=%b exp=1", req_ready); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL const_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_ram();
    req_valid = 1'b1; req_mblock = 2'd0; req_source = 8'h12;
    tick();
    req_valid = 1'b0;
    checks++; if (ram_rd_en !== 1'b1) begin failures++; $display("FAIL ram_rd_en_start got=%b exp=1", ram_rd_en); end
    checks++; if (ram_address !== 16'h0012) begin failures++; $display("FAIL ram_address got=%h exp=0012", ram_address); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ram_out_valid_wait got=%b exp=0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ram_rd_en !== 1'b1 || out_valid !== 1'b0) begin
        failures++; $display("FAIL ram_wait%0d rd_en=%b valid=%b exp rd_en=1 valid=0", i, ram_rd_en, out_valid);
      end
    end
    ram_rd_ack = 1'b1; ram_value = 32'hDEADBEEF;
    tick();
    ram_rd_ack = 1'b0; ram_value = 32'h0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ram_out_valid got=%b exp=1", out_valid); end
    checks++; if (vr_value !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_vr_value got=%h exp=deadbeef", vr_value); end
    checks++; if (ram_rd_en !== 1'b0) begin failures++; $display("FAIL ram_rd_en_done got=%b exp=0", ram_rd_en); end
    checks++; if (out_error !== 1'b0) begin failures++; $display("FAIL ram_out_error got=%b exp=0", out_error); end
    drain();
  endtask

  task automatic test_io_timeout();
    int high_cycles = 0;
    req_valid = 1'b1; req_mblock = 2'd2; req_source = 8'h03;
    tick();
    req_valid = 1'b0;
    checks++; if (io_device_id !== 8'h03) begin failures++; $display("FAIL io_device_id got=%h exp=03", io_device_id); end
    for (int i = 0; i < 40; i++) begin
      if (io_rd_en !== 1'b1) break;
      high_cycles++;
      tick();
    end
    checks++; if (high_cycles != 15) begin failures++; $display("FAIL io_timeout_len got=%0d exp=15", high_cycles); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL io_timeout_valid got=%b exp=1", out_valid); end
    checks++; if (out_error !== 1'b1) begin failures++; $display("FAIL io_timeout_error got=%b exp=1", out_error); end
    checks++; if (vr_value !== 32'h0) begin failures++; $display("FAIL io_timeout_value got=%h exp=0", vr_value); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL io_timeout_err_count got=%0d exp=1", err_count); end
    drain();
  endtask

  task automatic test_io_ack_last();
    req_valid = 1'b1; req_mblock = 2'd2; req_source = 8'h04;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if (io_rd_en !== 1'b1) begin failures++; $display("FAIL io_ack_rd_en_cycle%0d got=%b exp=1", i, io_rd_en); end
      if (i == 15) begin io_rd_ack = 1'b1; io_value = 32'h1; end
      tick();
    end
    io_rd_ack = 1'b0; io_value = 32'h0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL io_ack_valid got=%b exp=1", out_valid); end
    checks++; if (out_error !== 1'b0) begin failures++; $display("FAIL io_ack_error got=%b exp=0", out_error); end
    checks++; if (vr_value !== 32'h1) begin failures++; $display("FAIL io_ack_value got=%h exp=1", vr_value); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL io_ack_err_count got=%0d exp=1", err_count); end
    checks++; if (io_rd_en !== 1'b0) begin failures++; $display("FAIL io_ack_rd_en_off got=%b exp=0", io_rd_en); end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    req_valid = 1'b1; req_mblock = 2'd1; req_source = 8'h55;
    tick();
    checks++; if (out_valid !== 1'b1 || out_error !== 1'b1) begin failures++; $display("FAIL b2b_illegal valid=%b error=%b exp 1 1", out_valid, out_error); end
    checks++; if (vr_value !== 32'h0) begin failures++; $display("FAIL b2b_illegal_value got=%h exp=0", vr_value); end
    checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL b2b_err_count got=%0d exp=2", err_count); end
    req_mblock = 2'd3; req_source = 8'h07;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_req_ready got=%b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_const_valid got=%b exp=1", out_valid); end
    checks++; if (vr_value !== 32'h7) begin failures++; $display("FAIL b2b_const_value got=%h exp=7", vr_value); end
    checks++; if (out_error !== 1'b0) begin failures++; $display("FAIL b2b_const_error got=%b exp=0", out_error); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_mblock = 2'd0; req_source = 8'h5A;
    tick();
    req_valid = 1'b0;
    checks++; if (ram_rd_en !== 1'b1) begin failures++; $display("FAIL rst_mid_rd_en_before got=%b exp=1", ram_rd_en); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (ram_rd_en !== 1'b0) begin failures++; $display("FAIL rst_mid_rd_en_after got=%b exp=0", ram_rd_en); end
    ram_rd_ack = 1'b1; ram_value = 32'h12345678;
    tick();
    ram_rd_ack = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_late_ack_valid got=%b exp=0", out_valid); end
    checks++; if (vr_value !== 32'h0) begin failures++; $display("FAIL rst_mid_value got=%h exp=0", vr_value); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_idle_ready got=%b exp=1", req_ready); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL rst_mid_err_count got=%0d exp=0", err_count); end
  endtask

  initial begin
    test_reset();
    test_const();
    test_ram();
    test_io_timeout();
    test_io_ack_last();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/operand_fetch_ctrl.md
# operand_fetch_ctrl

Sequencing controller for the stage-1 operand fetch. It accepts one operand request at a time, carrying a 2-bit source select and an 8-bit source field. It drives a read handshake to RAM or to the input-device bus, or forms a zero-extended constant, and presents the 32-bit result to stage 2 through a valid/ready handshake. It sits between instruction decode and stage 2, and turns the purely combinational stage-1 source selection into a multi-cycle, stall-aware fetch with IO timeout and error reporting.

## Interface
- IO_TIMEOUT, default 15: maximum number of cycles `io_rd_en` stays high without `io_rd_ack` before the request fails. Legal range 1..255.
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  operand request valid
- req_ready  out  1  request accepted on a cycle where req_valid && req_ready
- req_mblock  in  2  source select: 0 = RAM, 1 = reserved/illegal, 2 = input device, 3 = constant
- req_source  in  8  RAM address low byte / device id / constant
- ram_rd_en  out  1  RAM read request, held until acked
- ram_address  out  16  {8'h00, latched req_source}
- ram_rd_ack  in  1  RAM read done; ram_value valid this cycle
- ram_value  in  32  RAM read data
- io_rd_en  out  1  device read request, held until ack or timeout
- io_device_id  out  8  latched req_source
- io_rd_ack  in  1  device read done; io_value valid this cycle
- io_value  in  32  device read data
- out_valid  out  1  vr_value/out_error valid for stage 2
- out_ready  in  1  stage 2 consumes on out_valid && out_ready
- vr_value  out  32  fetched operand
- out_error  out  1  result is an error (illegal select or IO timeout); vr_value = 0
- err_count  out  16  saturating count of error results produced

## Operation
- States: IDLE, RAM_WAIT, IO_WAIT, HOLD.
- `req_ready` = (state == IDLE) || (state == HOLD && out_ready). It is combinational from the state and out_ready. All other outputs are registered.
- On acceptance, latch req_source, then branch on req_mblock:
  - 0: go to RAM_WAIT, ram_rd_en = 1.
  - 2: go to IO_WAIT, io_rd_en = 1, timeout counter = 0.
  - 3: go to HOLD, vr_value = {24'h0, req_source}, out_error = 0.
  - 1: go to HOLD, vr_value = 0, out_error = 1.
- RAM_WAIT:
  - ram_rd_en stays high.
  - On ram_rd_ack, capture ram_value into vr_value, out_error = 0, ram_rd_en = 0, go to HOLD.
  - No timeout.
- IO_WAIT:
  - io_rd_en stays high; the counter increments each cycle without ack.
  - On io_rd_ack, capture io_value, out_error = 0, go to HOLD.
  - If no ack by the IO_TIMEOUT-th cycle of io_rd_en high: vr_value = 0, out_error = 1, io_rd_en = 0, go to HOLD.
  - An ack on the final (timeout) cycle wins; it is not an error.
- HOLD:
  - out_valid = 1; vr_value and out_error are stable until consumed.
  - On out_ready with no new request, go to IDLE and out_valid = 0.
  - On out_ready with a request accepted in the same cycle, go directly to the new request's state per the branch rules above. A constant or illegal request keeps out_valid = 1 with the new value.
- Acks outside the matching wait state are ignored. ram_address and io_device_id hold the last latched value outside wait states.
- err_count increments by 1 each time an error result enters HOLD, and saturates at 16'hFFFF.

## Timing
- Reset (reset_n = 0 at an edge):
  - state = IDLE.
  - ram_rd_en = io_rd_en = out_valid = out_error = 0.
  - vr_value = 0, ram_address = 0, io_device_id = 0, err_count = 0.
  - req_ready = 1 after reset.
- Reset mid-operation abandons the request. Enables drop at that edge; late acks are ignored.
- Constant/illegal: accepted at edge N, out_valid high from N+1.
- RAM: accepted at N, ram_rd_en high from N+1. Ack sampled at edge M ≥ N+1 gives out_valid from M+1.
- IO: accepted at N, io_rd_en high during cycles N+1..N+IO_TIMEOUT. With no ack, out_valid/out_error high from N+IO_TIMEOUT+1.
- Throughput: at most one request per HOLD drain; back-to-back constants sustain one result per cycle while out_ready = 1.

## Test plan
- Reset, then const request (mblock 3, source 8'hA5) at cycle 0 → out_valid at cycle 1, vr_value 32'h000000A5, out_error 0; hold 3 cycles with out_ready = 0, then drain.
- RAM request source 8'h12, ack after 4 cycles with ram_value 32'hDEADBEEF → ram_address 16'h0012 while ram_rd_en high; vr_value DEADBEEF one cycle after ack.
- IO request device 8'h03, no ack, IO_TIMEOUT = 15 → io_rd_en high exactly 15 cycles; out_error 1, vr_value 0, err_count 1.
- IO request with ack on exactly the 15th cycle, io_value 32'h1 → out_error 0, vr_value 1, err_count unchanged.
- Illegal mblock 1 followed by const 8'h07 presented while HOLD drains → error result, then vr_value 32'h7 on the very next cycle with out_valid continuous.
- reset_n low during RAM_WAIT, ack arrives after reset → ram_rd_en 0 the cycle after reset, no out_valid, state IDLE.
